// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-bit multi-cycle ALU with registered result/flags and start/busy/done handshake
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : operation request, honoured only while busy=0
//   A, B       : operands (B[$clog2(WIDTH)-1:0] is the shift amount for SHL/ASR)
//   ALUcontrol : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 ASR
//   Risultato  : registered result
//   ALUflags   : registered flags {V, C, Z, N}
//   busy       : multi-cycle operation in progress
//   done       : one-cycle pulse when Risultato/ALUflags are updated
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUcontrol,
  output logic [WIDTH-1:0] Risultato,
  output logic [3:0]       ALUflags,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   sh;
  logic               sh_c;
  logic [CW-1:0]      cnt;

  logic [SW-1:0]      shamt;
  logic               is_multi;
  logic               accept;
  logic               last;

  assign shamt    = B[SW-1:0];
  assign is_multi = (ALUcontrol == OP_MUL) || (ALUcontrol[2:1] == 2'b11 && shamt != '0);
  assign accept   = start && (state == IDLE);
  assign last     = (state == RUN) && (cnt == CW'(1));
  assign busy     = (state == RUN);

  // Single-cycle result path (also covers SHL/ASR by zero: result is A, C=0)
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] r1;
  logic             c1, v1;

  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
    r1   = A;
    c1   = 1'b0;
    v1   = 1'b0;
    case (ALUcontrol)
      OP_ADD: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = (A[WIDTH-1] == B[WIDTH-1]) && (r1[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r1 = diff[WIDTH-1:0];
        c1 = diff[WIDTH];  // borrow: A < B unsigned
        v1 = (A[WIDTH-1] != B[WIDTH-1]) && (r1[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  r1 = A & B;
      OP_OR:   r1 = A | B;
      OP_XOR:  r1 = A ^ B;
      default: r1 = A;
    endcase
  end

  // One iteration of the multi-cycle ops; on the last edge the iterated value is the final one
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH-1:0]   sh_n;
  logic               sh_c_n;
  logic [WIDTH-1:0]   rf;
  logic               cf;

  always_comb begin
    acc_n = mplier[0] ? (acc + mcand) : acc;
    if (op_q == OP_SHL) begin
      sh_n   = {sh[WIDTH-2:0], 1'b0};
      sh_c_n = sh[WIDTH-1];
    end else begin
      sh_n   = {sh[WIDTH-1], sh[WIDTH-1:1]};
      sh_c_n = sh[0];
    end
    if (op_q == OP_MUL) begin
      rf = acc_n[WIDTH-1:0];
      cf = |acc_n[2*WIDTH-1:WIDTH];
    end else begin
      rf = sh_n;
      cf = sh_c_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_multi) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Risultato <= '0;
      ALUflags  <= '0;
      done      <= 1'b0;
      op_q      <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sh        <= '0;
      sh_c      <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q <= ALUcontrol;
        if (is_multi) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, A};
          mplier <= B;
          sh     <= A;
          sh_c   <= 1'b0;
          cnt    <= (ALUcontrol == OP_MUL) ? CW'(WIDTH) : {1'b0, shamt};
        end else begin
          Risultato <= r1;
          ALUflags  <= {v1, c1, (r1 == '0), r1[WIDTH-1]};
          done      <= 1'b1;
        end
      end else if (state == RUN) begin
        acc    <= acc_n;
        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
        mplier <= {1'b0, mplier[WIDTH-1:1]};
        sh     <= sh_n;
        sh_c   <= sh_c_n;
        cnt    <= cnt - CW'(1);
        if (last) begin
          Risultato <= rf;
          ALUflags  <= {1'b0, cf, (rf == '0), rf[WIDTH-1]};
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard testbench for alu_seq with randomized stimulus and reference model
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A, B;
  logic [2:0] ALUcontrol;
  logic [7:0] Risultato;
  logic [3:0] ALUflags;
  logic       busy, done;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .ALUcontrol(ALUcontrol), .Risultato(Risultato), .ALUflags(ALUflags),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flags;
    int         due;
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: flags packed {V, C, Z, N}
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int         s, p;
    logic [7:0] r;
    logic       c, v;
    s = int'(b[2:0]);
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        p = int'(a) + int'(b);
        r = p[7:0];
        c = (p > 255);
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        p = int'(a) * int'(b);
        r = p[7:0];
        c = (p > 255);
      end
      3'd6: begin
        r = a << s;
        if (s > 0) c = a[8 - s];
      end
      default: begin
        r = $signed(a) >>> s;
        if (s > 0) c = a[s - 1];
      end
    endcase
    return {v, c, (r == 8'h00), r[7], r};
  endfunction

  function automatic int iters(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd5) return 8;
    if (op >= 3'd6) return int'(b[2:0]);
    return 0;
  endfunction

  // Waits (at negedges) for busy=0; optionally pokes start with junk while busy to test it is ignored
  task automatic wait_idle(input bit noise);
    int n = 0;
    while (busy && n < 100) begin
      if (noise) begin
        start      = 1'($urandom_range(0, 1));
        ALUcontrol = 3'd0;
        A          = 8'($urandom);
        B          = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy stuck high");
    end
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit use_model, input logic [7:0] res, input logic [3:0] flags, input bit noise);
    exp_t       e;
    logic [11:0] m;
    int         n;
    wait_idle(noise);
    n = iters(op, b);
    m = model(op, a, b);
    e.res   = use_model ? m[7:0] : res;
    e.flags = use_model ? m[11:8] : flags;
    e.due   = cyc + 1 + n;
    e.name  = name;
    sb.push_back(e);
    A = a; B = b; ALUcontrol = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'(n > 0));
  endtask

  // Monitor: one scoreboard entry per done pulse, also checks completion cycle
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: Risultato=%0h at cycle %0d", Risultato, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_res"}, 32'(Risultato), 32'(e.res));
        chk({e.name, "_flags"}, 32'(ALUflags), 32'(e.flags));
        chk({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUcontrol = '0;
    repeat (2) @(negedge clk);
    chk("reset_res", 32'(Risultato), 0);
    chk("reset_flags", 32'(ALUflags), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations, issued back to back
    issue("add_ovf",   3'd0, 8'h7F, 8'h01, 0, 8'h80, 4'b1001, 0);
    issue("add_carry", 3'd0, 8'hFF, 8'h01, 0, 8'h00, 4'b0110, 0);
    issue("sub_zero",  3'd1, 8'h05, 8'h05, 0, 8'h00, 4'b0010, 0);
    issue("sub_borrow",3'd1, 8'h03, 8'h05, 0, 8'hFE, 4'b0101, 0);
    issue("sub_ovf",   3'd1, 8'h80, 8'h01, 0, 8'h7F, 4'b1000, 0);
    issue("mul_hi",    3'd5, 8'h10, 8'h10, 0, 8'h00, 4'b0110, 0);
    issue("mul_lo",    3'd5, 8'h0F, 8'h03, 0, 8'h2D, 4'b0000, 0);
    issue("asr3",      3'd7, 8'h80, 8'h03, 0, 8'hF0, 4'b0001, 0);
    issue("shl1",      3'd6, 8'h81, 8'h01, 0, 8'h02, 4'b0100, 0);
    issue("shl0",      3'd6, 8'h5A, 8'h00, 0, 8'h5A, 4'b0000, 0);
    // MUL with start/ADD noise while busy: junk starts must not produce results
    issue("mul_noisy", 3'd5, 8'hC3, 8'h27, 1, 8'h00, 4'b0000, 0);
    issue("add_after", 3'd0, 8'h11, 8'h22, 0, 8'h33, 4'b0000, 1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      issue("rand", op, 8'($urandom), 8'($urandom), 1, 8'h00, 4'h0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset three cycles into a MUL: outputs clear with no clock edge
    wait_idle(0);
    repeat (3) @(negedge clk);
    A = 8'hFF; B = 8'hFF; ALUcontrol = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_res", 32'(Risultato), 0);
    chk("abort_flags", 32'(ALUflags), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue("add_post_reset", 3'd0, 8'h40, 8'h40, 0, 8'h80, 4'b1001, 0);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
